reg_file_param: RTL and testbench

Parametrised configuration/status register file for the system-control path. It generalises the 8x8 single-port register file in four ways: configurable depth and width, per-register reset values, per-register read-only and clear-on-read masks, and a configurable read latency. It also adds an error flag for illegal accesses and exports the first NUM_EXPORT registers as a flat bus to the datapath blocks (ALU, UART config, clock divider).

---
 rtl/reg_file_pkg.sv | 19 +
 rtl/reg_file_if.sv | 26 ++
 rtl/reg_file_rd_pipe.sv | 68 ++++++
 rtl/reg_file_param.sv | 84 ++++++++
 tb/tb_reg_file_param.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_param shared types and constants.
// Default reset image and the system register map.
package reg_file_pkg;

  localparam logic [31:0] RST_DEF = 32'h2081_0000;

  localparam int REG_ALU_A     = 0;
  localparam int REG_ALU_B     = 1;
  localparam int REG_UART_CFG  = 2;
  localparam int REG_DIV_RATIO = 3;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_WR,
    ACC_RD,
    ACC_ILLEGAL
  } acc_t;

endpackage

// File: rtl/reg_file_if.sv
// Register file bus: request side plus read/err/export returns.
// Master drives requests, slave is the register file.
interface reg_file_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR       = 4,
  parameter int NUM_EXPORT = 4
);
  logic                        WrEn;
  logic                        RdEn;
  logic [ADDR-1:0]             Address;
  logic [WIDTH-1:0]            WrData;
  logic [WIDTH-1:0]            RdData;
  logic                        RdData_Valid;
  logic                        Err;
  logic [NUM_EXPORT*WIDTH-1:0] CfgOut;

  modport master (
    output WrEn, RdEn, Address, WrData,
    input  RdData, RdData_Valid, Err, CfgOut
  );

  modport slave (
    input  WrEn, RdEn, Address, WrData,
    output RdData, RdData_Valid, Err, CfgOut
  );
endinterface

// File: rtl/reg_file_rd_pipe.sv
// Read response pipeline, one or two stages.
// Write/illegal errors bypass the read latency.
module reg_file_rd_pipe #(
  parameter int WIDTH  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             rd_req,
  input  logic [WIDTH-1:0] rd_data,
  input  logic             rd_err,
  input  logic             imm_err,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_err
);
  logic             v1;
  logic             e1;
  logic             ie;
  logic [WIDTH-1:0] d1;
  logic             ve;
  logic             ee;

  // First stage: data held between reads
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      v1 <= 1'b0;
      e1 <= 1'b0;
      ie <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= rd_req;
      e1 <= rd_err;
      ie <= imm_err;
      if (rd_req) d1 <= rd_data;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic             v2;
    logic             e2;
    logic [WIDTH-1:0] d2;

    // Extra stage keeps responses in order
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        v2 <= 1'b0;
        e2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        e2 <= e1;
        if (v1) d2 <= d1;
      end
    end

    assign out_data = d2;
    assign ve       = v2;
    assign ee       = e2;
  end else begin : g_lat1
    assign out_data = d1;
    assign ve       = v1;
    assign ee       = e1;
  end

  assign out_valid = ve;
  assign out_err   = ee | ie;
endmodule

// File: rtl/reg_file_param.sv
// Parametrised config/status register file.
// Storage, decode and masks; reads go via rd_pipe.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int                     WIDTH      = 8,
  parameter int                     DEPTH      = 16,
  parameter int                     ADDR       = 4,
  parameter logic [DEPTH*WIDTH-1:0] RST_VALS   = (DEPTH*WIDTH)'(RST_DEF),
  parameter logic [DEPTH-1:0]       RO_MASK    = '0,
  parameter logic [DEPTH-1:0]       COR_MASK   = '0,
  parameter int                     RD_LAT     = 1,
  parameter int                     NUM_EXPORT = 4
) (
  input  logic      CLK,
  input  logic      RST,
  reg_file_if.slave bus
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rv  [DEPTH];
  acc_t             acc;
  logic             in_range;
  logic [ADDR-1:0]  idx;
  logic             wr_ok;
  logic             rd_req;
  logic             rd_clr;
  logic             rd_err;
  logic             imm_err;
  logic [WIDTH-1:0] rd_val;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rv
    assign rv[g] = RST_VALS[g*WIDTH +: WIDTH];
  end

  // Classify the request on the bus
  always_comb begin
    acc = ACC_IDLE;
    unique case (1'b1)
      bus.WrEn && bus.RdEn:  acc = ACC_ILLEGAL;
      bus.WrEn && !bus.RdEn: acc = ACC_WR;
      bus.RdEn && !bus.WrEn: acc = ACC_RD;
      default:               acc = ACC_IDLE;
    endcase
  end

  assign in_range = {1'b0, bus.Address} < (ADDR+1)'(DEPTH);
  assign idx      = in_range ? bus.Address : '0;
  assign wr_ok    = (acc == ACC_WR) && in_range && !RO_MASK[idx];
  assign rd_req   = (acc == ACC_RD);
  assign rd_clr   = rd_req && in_range && COR_MASK[idx];
  assign rd_err   = rd_req && !in_range;
  assign imm_err  = (acc == ACC_ILLEGAL) || ((acc == ACC_WR) && !wr_ok);
  assign rd_val   = in_range ? mem[idx] : '0;

  // Storage: write, or clear-on-read back to reset image
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= rv[i];
    end else if (wr_ok) begin
      mem[idx] <= bus.WrData;
    end else if (rd_clr) begin
      mem[idx] <= rv[idx];
    end
  end

  for (genvar g = 0; g < NUM_EXPORT; g++) begin : g_exp
    assign bus.CfgOut[g*WIDTH +: WIDTH] = mem[g];
  end

  reg_file_rd_pipe #(
    .WIDTH  (WIDTH),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .CLK       (CLK),
    .RST       (RST),
    .rd_req    (rd_req),
    .rd_data   (rd_val),
    .rd_err    (rd_err),
    .imm_err   (imm_err),
    .out_data  (bus.RdData),
    .out_valid (bus.RdData_Valid),
    .out_err   (bus.Err)
  );
endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench: DUT1 depth 12 latency 1,
// DUT2 depth 16 latency 2, same request stream.
module tb_reg_file_param;
  logic CLK;
  logic RST;
  int   n_chk;
  int   n_err;

  reg_file_if #(.WIDTH(8), .ADDR(4), .NUM_EXPORT(4)) if1 ();
  reg_file_if #(.WIDTH(8), .ADDR(4), .NUM_EXPORT(4)) if2 ();

  reg_file_param #(
    .WIDTH(8), .DEPTH(12), .ADDR(4),
    .RST_VALS(96'h2081_0000),
    .RO_MASK(12'h002), .COR_MASK(12'h040),
    .RD_LAT(1), .NUM_EXPORT(4)
  ) dut1 (
    .CLK(CLK), .RST(RST), .bus(if1)
  );

  reg_file_param #(
    .WIDTH(8), .DEPTH(16), .ADDR(4),
    .RST_VALS(128'h2081_0000),
    .RO_MASK(16'h0002), .COR_MASK(16'h0040),
    .RD_LAT(2), .NUM_EXPORT(4)
  ) dut2 (
    .CLK(CLK), .RST(RST), .bus(if2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic w, input logic r,
                      input logic [3:0] a,
                      input logic [7:0] d);
    if1.WrEn = w; if1.RdEn = r;
    if1.Address = a; if1.WrData = d;
    if2.WrEn = w; if2.RdEn = r;
    if2.Address = a; if2.WrData = d;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic see1(input string tag, input logic [7:0] rd,
                      input logic v, input logic e);
    chk({tag, ".d1"}, 32'(if1.RdData), 32'(rd));
    chk({tag, ".v1"}, 32'(if1.RdData_Valid), 32'(v));
    chk({tag, ".e1"}, 32'(if1.Err), 32'(e));
  endtask

  task automatic see2(input string tag, input logic [7:0] rd,
                      input logic v, input logic e);
    chk({tag, ".d2"}, 32'(if2.RdData), 32'(rd));
    chk({tag, ".v2"}, 32'(if2.RdData_Valid), 32'(v));
    chk({tag, ".e2"}, 32'(if2.Err), 32'(e));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    RST = 1'b0;
    tick(1'b0, 1'b0, 4'h0, 8'h00);
    see1("rst", 8'h00, 1'b0, 1'b0);
    see2("rst", 8'h00, 1'b0, 1'b0);
    chk("rst.cfg1", if1.CfgOut, 32'h2081_0000);
    chk("rst.cfg2", if2.CfgOut, 32'h2081_0000);
    RST = 1'b1;

    tick(1'b0, 1'b1, 4'h0, 8'h00);
    see1("rd0", 8'h00, 1'b1, 1'b0);
    chk("rd0.v2", 32'(if2.RdData_Valid), 32'd0);
    tick(1'b0, 1'b1, 4'h1, 8'h00);
    see1("rd1", 8'h00, 1'b1, 1'b0);
    see2("rd1", 8'h00, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 4'h2, 8'h00);
    see1("rd2", 8'h81, 1'b1, 1'b0);
    see2("rd2", 8'h00, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 4'h3, 8'h00);
    see1("rd3", 8'h20, 1'b1, 1'b0);
    see2("rd3", 8'h81, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 4'h0, 8'h00);
    see1("hold", 8'h20, 1'b0, 1'b0);
    see2("hold", 8'h20, 1'b1, 1'b0);

    tick(1'b1, 1'b0, 4'h5, 8'hA5);
    see1("wr5", 8'h20, 1'b0, 1'b0);
    see2("wr5", 8'h20, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 4'h5, 8'h00);
    see1("rd5", 8'hA5, 1'b1, 1'b0);
    chk("rd5.v2", 32'(if2.RdData_Valid), 32'd0);
    tick(1'b0, 1'b0, 4'h0, 8'h00);
    see1("rd5b", 8'hA5, 1'b0, 1'b0);
    see2("rd5b", 8'hA5, 1'b1, 1'b0);

    tick(1'b1, 1'b0, 4'h1, 8'h3C);
    see1("ro", 8'hA5, 1'b0, 1'b1);
    see2("ro", 8'hA5, 1'b0, 1'b1);
    chk("ro.cfg1", if1.CfgOut, 32'h2081_0000);
    chk("ro.cfg2", if2.CfgOut, 32'h2081_0000);
    tick(1'b0, 1'b0, 4'h0, 8'h00);
    chk("ro.e1off", 32'(if1.Err), 32'd0);
    chk("ro.e2off", 32'(if2.Err), 32'd0);

    tick(1'b0, 1'b1, 4'hE, 8'h00);
    see1("oob", 8'h00, 1'b1, 1'b1);
    see2("oob", 8'hA5, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 4'h0, 8'h00);
    see1("oobb", 8'h00, 1'b0, 1'b0);
    see2("oobb", 8'h00, 1'b1, 1'b0);

    tick(1'b1, 1'b0, 4'h6, 8'h77);
    tick(1'b0, 1'b1, 4'h6, 8'h00);
    see1("cor1", 8'h77, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 4'h6, 8'h00);
    see1("cor2", 8'h00, 1'b1, 1'b0);
    see2("cor1", 8'h77, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 4'h0, 8'h00);
    see2("cor2", 8'h00, 1'b1, 1'b0);

    tick(1'b1, 1'b1, 4'h2, 8'hFF);
    see1("both", 8'h00, 1'b0, 1'b1);
    see2("both", 8'h00, 1'b0, 1'b1);
    chk("both.cfg1", if1.CfgOut, 32'h2081_0000);
    chk("both.cfg2", if2.CfgOut, 32'h2081_0000);
    tick(1'b0, 1'b0, 4'h0, 8'h00);
    see1("bothb", 8'h00, 1'b0, 1'b0);
    see2("bothb", 8'h00, 1'b0, 1'b0);

    tick(1'b1, 1'b0, 4'h0, 8'h11);
    chk("wr0.cfg1", if1.CfgOut, 32'h2081_0011);
    chk("wr0.cfg2", if2.CfgOut, 32'h2081_0011);
    tick(1'b0, 1'b1, 4'h0, 8'h00);
    tick(1'b0, 1'b1, 4'h2, 8'h00);
    see2("bur1", 8'h11, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 4'h3, 8'h00);
    see2("bur2", 8'h81, 1'b1, 1'b0);
    RST = 1'b0;
    #1;
    see1("mrst", 8'h00, 1'b0, 1'b0);
    see2("mrst", 8'h00, 1'b0, 1'b0);
    chk("mrst.cfg1", if1.CfgOut, 32'h2081_0000);
    chk("mrst.cfg2", if2.CfgOut, 32'h2081_0000);
    @(negedge CLK);
    RST = 1'b1;
    tick(1'b0, 1'b0, 4'h0, 8'h00);
    see1("post1", 8'h00, 1'b0, 1'b0);
    see2("post1", 8'h00, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 4'h0, 8'h00);
    see2("post2", 8'h00, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
